// File: rtl/draw_pkg.sv
// Shared types and helpers for the rectangle drawer: FSM states, default screen size,
// ROM address width and a shift-add row offset used instead of a multiplier.
package draw_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} draw_state_e;

    localparam int unsigned ScreenWDefault = 160;
    localparam int unsigned ScreenHDefault = 120;

    function automatic int unsigned addr_width(int unsigned w, int unsigned h);
        return $clog2(w * h);
    endfunction

    // y * w built from shifted copies of y; with w constant this folds to a few adders.
    function automatic int unsigned row_offset(int unsigned y, int unsigned w);
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            if (w[i]) acc = acc + (y << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/draw_delay_line.sv
// DEPTH-stage shift register carrying a valid bit and a data word alongside the ROM read.
module draw_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/draw_region.sv
// Sweeps a rectangle of a ROM-backed image to the VGA adapter, one pixel per clock.
// Define DRAW_REGION_TRANSPARENT_EN to suppress plots of pixels equal to TRANSPARENT_KEY.
module draw_region
    import draw_pkg::*;
#(
    parameter int unsigned          SCREEN_W        = ScreenWDefault,
    parameter int unsigned          SCREEN_H        = ScreenHDefault,
    parameter int unsigned          X_W             = 8,
    parameter int unsigned          Y_W             = 7,
    parameter int unsigned          ADDR_W          = addr_width(SCREEN_W, SCREEN_H),
    parameter int unsigned          COLOUR_W        = 3,
    parameter int unsigned          ROM_LAT         = 1,
    parameter logic [COLOUR_W-1:0]  TRANSPARENT_KEY = '0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      rect_x0,
    input  logic [Y_W-1:0]      rect_y0,
    input  logic [X_W-1:0]      rect_w,
    input  logic [Y_W-1:0]      rect_h,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [X_W:0] XOne      = (X_W+1)'(1);
    localparam logic [Y_W:0] YOne      = (Y_W+1)'(1);
    localparam logic [X_W:0] XLim      = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] YLim      = (Y_W+1)'(SCREEN_H);
    localparam logic [2:0]   DrainLast = 3'(ROM_LAT);

    draw_state_e         state_q, state_d;
    logic [X_W:0]        cx_q, cx_d, x0_q, x0_d, xend_q, xend_d;
    logic [Y_W:0]        cy_q, cy_d, yend_q, yend_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d, rom_addr_q, rom_addr_d;
    logic                iss_valid_q, iss_valid_d, issue_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [2:0]          drain_q, drain_d;
    logic [X_W-1:0]      vga_x_q, vga_x_d, dly_x;
    logic [Y_W-1:0]      vga_y_q, vga_y_d, dly_y;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d, dly_valid, pix_show;

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        x0_d       = x0_q;
        xend_d     = xend_q;
        yend_d     = yend_q;
        row_base_d = row_base_q;
        rom_addr_d = rom_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        drain_d    = drain_q;
        issue_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d     = 1'b1;
                    x0_d       = {1'b0, rect_x0};
                    cx_d       = {1'b0, rect_x0};
                    cy_d       = {1'b0, rect_y0};
                    xend_d     = {1'b0, rect_x0} + {1'b0, rect_w};
                    yend_d     = {1'b0, rect_y0} + {1'b0, rect_h};
                    row_base_d = ADDR_W'(row_offset(32'(rect_y0), SCREEN_W));
                    if (rect_w == '0 || rect_h == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StRun;
                        issue_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (cx_q + XOne == xend_q) begin
                    if (cy_q + YOne == yend_q) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        cx_d       = x0_q;
                        cy_d       = cy_q + YOne;
                        row_base_d = row_base_q + ADDR_W'(SCREEN_W);
                        issue_d    = 1'b1;
                    end
                end else begin
                    cx_d    = cx_q + XOne;
                    issue_d = 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) state_d = StFin;
                else drain_d = drain_q + 3'd1;
            end
            StFin: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // Off-screen pixels still take their issue slot but leave the ROM address alone.
        iss_valid_d = issue_d && (cx_d < XLim) && (cy_d < YLim);
        if (iss_valid_d) rom_addr_d = row_base_d + ADDR_W'(cx_d);
    end

    draw_delay_line #(
        .DEPTH (ROM_LAT),
        .WIDTH (X_W + Y_W)
    ) u_delay (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (iss_valid_q),
        .in_data   ({cx_q[X_W-1:0], cy_q[Y_W-1:0]}),
        .out_valid (dly_valid),
        .out_data  ({dly_x, dly_y})
    );

`ifdef DRAW_REGION_TRANSPARENT_EN
    assign pix_show = (rom_data != TRANSPARENT_KEY);
`else
    logic unused_key;
    assign pix_show   = 1'b1;
    assign unused_key = ^TRANSPARENT_KEY;
`endif

    always_comb begin
        vga_x_d  = vga_x_q;
        vga_y_d  = vga_y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (dly_valid) begin
            vga_x_d  = dly_x;
            vga_y_d  = dly_y;
            colour_d = rom_data;
            plot_d   = pix_show;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cx_q        <= '0;
            cy_q        <= '0;
            x0_q        <= '0;
            xend_q      <= '0;
            yend_q      <= '0;
            row_base_q  <= '0;
            rom_addr_q  <= '0;
            iss_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_q     <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            x0_q        <= x0_d;
            xend_q      <= xend_d;
            yend_q      <= yend_d;
            row_base_q  <= row_base_d;
            rom_addr_q  <= rom_addr_d;
            iss_valid_q <= iss_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drain_q     <= drain_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign vga_x    = vga_x_q;
    assign vga_y    = vga_y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
